// File: rtl/regfile_sb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sb_pkg
//  Description : Shared constants and types for the register file and its
//                in-flight-writer scoreboard.
//                RF_NUM          - architectural register count (r0..r31)
//                RF_ADDR_W       - register address width
//                RF_SB_CNT_W     - scoreboard counter width per register
//                WS_TO_RF_BUS_WD - width of the WB -> RF bus {we, waddr, wdata}
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_sb_pkg;

    localparam int RF_NUM          = 32;
    localparam int RF_ADDR_W       = 5;
    localparam int RF_SB_CNT_W     = 2;
    localparam int WS_TO_RF_BUS_WD = 38;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;

endpackage : regfile_sb_pkg
`default_nettype wire

// File: rtl/regfile_sb_sb_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sb_counter
//  Description : One scoreboard entry: a saturating up/down counter tracking
//                the number of in-flight writers to a single register.
//  Ports       : clk      - pipeline clock
//                resetn   - asynchronous active-low reset (count -> 0)
//                claim_i  - a new writer was issued to this register
//                retire_i - a writer retired (WB wrote this register)
//                clear_i  - synchronous clear, overrides claim/retire
//                cnt_o    - current in-flight writer count
//  Revision    : 1.0 - initial release
// ============================================================================
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             claim_i,
    input  logic             retire_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Claim and retire together cancel out. Both directions saturate so a
    // protocol error (retire at 0, claim at max) can never wrap the count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (claim_i && !retire_i) begin
            if (cnt_q != C_CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (retire_i && !claim_i) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : sb_counter
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sb
//  Description : Architectural register file (r1..r31, r0 hard-wired to 0)
//                with two combinational read ports, same-cycle write bypass
//                and a per-register in-flight-writer scoreboard.
//  Ports       : clk, resetn      - clock, asynchronous active-low reset
//                ws_to_rf_bus     - {rf_we, rf_waddr, rf_wdata} from WB
//                raddr1/raddr2    - read addresses
//                rdata1/rdata2    - read data (bypassed from WB when hit)
//                r1_busy/r2_busy  - read register has an unretired writer
//                issue_valid      - ID issues a register-writing instruction
//                issue_dest       - destination of that instruction
//                issue_ready      - scoreboard can accept the claim
//                sb_clear         - flush: clear all scoreboard counters
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = RF_SB_CNT_W
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [DATA_W+RF_ADDR_W:0]     ws_to_rf_bus,
    input  logic [RF_ADDR_W-1:0]          raddr1,
    input  logic [RF_ADDR_W-1:0]          raddr2,
    output logic [DATA_W-1:0]             rdata1,
    output logic [DATA_W-1:0]             rdata2,
    output logic                          r1_busy,
    output logic                          r2_busy,
    input  logic                          issue_valid,
    input  logic [RF_ADDR_W-1:0]          issue_dest,
    output logic                          issue_ready,
    input  logic                          sb_clear
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Write-back bus unpack
    // ------------------------------------------------------------------
    logic              w_rf_we;
    rf_addr_t          w_rf_waddr;
    logic [DATA_W-1:0] w_rf_wdata;

    assign {w_rf_we, w_rf_waddr, w_rf_wdata} = ws_to_rf_bus;

    // A write to r0 neither stores anything nor retires a claim.
    logic w_retire;
    assign w_retire = w_rf_we && (w_rf_waddr != '0);

    // ------------------------------------------------------------------
    // Register storage (r0 is not stored)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] regs_q [1:RF_NUM-1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 1; i < RF_NUM; i++) begin
                regs_q[i] <= '0;
            end
        end else if (w_retire) begin
            regs_q[w_rf_waddr] <= w_rf_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] w_cnt [RF_NUM];
    logic             w_claim;
    logic             w_dest_retiring;

    assign w_cnt[0]        = '0;
    assign w_dest_retiring = w_retire && (w_rf_waddr == issue_dest);

    // A full counter can still take a claim when the same register retires
    // in this cycle, since the two updates cancel.
    assign issue_ready = !resetn ||
                         !((issue_dest != '0) &&
                           (w_cnt[issue_dest] == C_CNT_MAX) &&
                           !w_dest_retiring);

    assign w_claim = issue_valid && issue_ready && (issue_dest != '0);

    generate
        for (genvar g = 1; g < RF_NUM; g++) begin : g_cnt
            sb_counter #(
                .CNT_W (CNT_W)
            ) u_sb_counter (
                .clk      (clk),
                .resetn   (resetn),
                .claim_i  (w_claim  && (issue_dest == RF_ADDR_W'(g))),
                .retire_i (w_retire && (w_rf_waddr == RF_ADDR_W'(g))),
                .clear_i  (sb_clear),
                .cnt_o    (w_cnt[g])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    logic             w_hit1;
    logic             w_hit2;
    logic [CNT_W-1:0] w_eff1;
    logic [CNT_W-1:0] w_eff2;

    assign w_hit1 = w_retire && (w_rf_waddr == raddr1);
    assign w_hit2 = w_retire && (w_rf_waddr == raddr2);

    // Writers still outstanding after this cycle's retire; a register whose
    // last writer is retiring now is served by the bypass, so it is not busy.
    assign w_eff1 = w_cnt[raddr1] - CNT_W'(w_hit1);
    assign w_eff2 = w_cnt[raddr2] - CNT_W'(w_hit2);

    always_comb begin
        rdata1 = '0;
        if (resetn && (raddr1 != '0)) begin
            rdata1 = w_hit1 ? w_rf_wdata : regs_q[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (resetn && (raddr2 != '0)) begin
            rdata2 = w_hit2 ? w_rf_wdata : regs_q[raddr2];
        end
    end

    assign r1_busy = resetn && (raddr1 != '0) && (w_eff1 != '0);
    assign r2_busy = resetn && (raddr2 != '0) && (w_eff2 != '0);

endmodule : regfile_sb
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_sb
//  Description : Self-checking bench for regfile_sb: directed scenarios
//                followed by randomized traffic, compared every cycle against
//                an array-based model of registers and writer counts.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    localparam int C_MAX_CNT = 3;

    logic        clk = 1'b0;
    logic        resetn;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic        r1_busy, r2_busy;
    logic        issue_valid;
    logic [4:0]  issue_dest;
    logic        issue_ready;
    logic        sb_clear;
    logic [37:0] ws_to_rf_bus;

    assign ws_to_rf_bus = {we, waddr, wdata};

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mreg [32];
    int          mcnt [32];

    always #5 clk = ~clk;

    regfile_sb u_dut (
        .clk          (clk),
        .resetn       (resetn),
        .ws_to_rf_bus (ws_to_rf_bus),
        .raddr1       (raddr1),
        .raddr2       (raddr2),
        .rdata1       (rdata1),
        .rdata2       (rdata2),
        .r1_busy      (r1_busy),
        .r2_busy      (r2_busy),
        .issue_valid  (issue_valid),
        .issue_dest   (issue_dest),
        .issue_ready  (issue_ready),
        .sb_clear     (sb_clear)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_retire();
        return resetn && we && (waddr != 0);
    endfunction

    function automatic logic [31:0] m_rdata(input logic [4:0] a);
        if (!resetn || a == 0) return 32'h0;
        if (m_retire() && waddr == a) return wdata;
        return mreg[a];
    endfunction

    function automatic bit m_busy(input logic [4:0] a);
        int remaining;
        if (!resetn || a == 0) return 1'b0;
        remaining = mcnt[a] - ((m_retire() && waddr == a) ? 1 : 0);
        return remaining > 0;
    endfunction

    function automatic bit m_ready();
        if (!resetn || issue_dest == 0) return 1'b1;
        if (mcnt[issue_dest] < C_MAX_CNT) return 1'b1;
        return m_retire() && waddr == issue_dest;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            mreg[i] = 32'h0;
            mcnt[i] = 0;
        end
    endtask

    task automatic check_all(input string tag);
        #1;
        chk({tag, ".rdata1"}, rdata1, m_rdata(raddr1));
        chk({tag, ".rdata2"}, rdata2, m_rdata(raddr2));
        chk({tag, ".r1_busy"}, 32'(r1_busy), 32'(m_busy(raddr1)));
        chk({tag, ".r2_busy"}, 32'(r2_busy), 32'(m_busy(raddr2)));
        chk({tag, ".issue_ready"}, 32'(issue_ready), 32'(m_ready()));
    endtask

    // Advance one clock: apply the model update for the inputs held across
    // the rising edge, then return at the falling edge for new stimulus.
    task automatic step();
        bit claim;
        @(posedge clk);
        if (resetn) begin
            if (m_retire()) begin
                assert (mcnt[waddr] > 0)
                    else $error("retire of r%0d with no outstanding writer", waddr);
            end
            claim = issue_valid && m_ready() && issue_dest != 0;
            if (sb_clear) begin
                for (int i = 0; i < 32; i++) mcnt[i] = 0;
            end else begin
                if (claim) mcnt[issue_dest]++;
                if (m_retire() && mcnt[waddr] > 0) mcnt[waddr]--;
            end
            if (m_retire()) mreg[waddr] = wdata;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        we = 1'b0; waddr = 5'd0; wdata = 32'h0;
        issue_valid = 1'b0; issue_dest = 5'd0; sb_clear = 1'b0;
    endtask

    task automatic claim(input logic [4:0] d);
        idle();
        issue_valid = 1'b1; issue_dest = d;
        step();
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        m_reset();
        idle();
        raddr1 = 5'd5; raddr2 = 5'd0;
        resetn = 1'b0;
        // Bus activity during reset must not leak to the outputs.
        wb(5'd5, 32'hABCD_0123);
        issue_valid = 1'b1; issue_dest = 5'd5;
        repeat (3) @(negedge clk);
        check_all("in_reset");
        idle();
        resetn = 1'b1;
        check_all("post_reset");

        // Write then read with bypass
        claim(5'd7);
        raddr1 = 5'd7; wb(5'd7, 32'hDEAD_BEEF);
        check_all("bypass");
        chk("bypass_val", rdata1, 32'hDEAD_BEEF);
        step();
        idle();
        check_all("stored");
        chk("stored_val", rdata1, 32'hDEAD_BEEF);
        raddr2 = 5'd0; wb(5'd0, 32'h1234);
        check_all("r0_write");
        step();
        idle();
        check_all("r0_after");

        // Claim / retire latency on r9
        raddr1 = 5'd9;
        issue_valid = 1'b1; issue_dest = 5'd9;
        step();
        idle();
        check_all("r9_busy_c1");
        chk("r9_busy_val", 32'(r1_busy), 32'd1);
        step();
        check_all("r9_busy_c2");
        step();
        wb(5'd9, 32'h55);
        check_all("r9_retire");
        chk("r9_retire_busy", 32'(r1_busy), 32'd0);
        step();

        // Saturation on r3
        raddr1 = 5'd3;
        for (int i = 0; i < 3; i++) begin
            idle(); issue_valid = 1'b1; issue_dest = 5'd3;
            check_all("sat_claim");
            step();
        end
        idle(); issue_valid = 1'b1; issue_dest = 5'd3;
        check_all("sat_full");
        chk("sat_full_ready", 32'(issue_ready), 32'd0);
        wb(5'd3, 32'h3333);
        check_all("sat_retire");
        chk("sat_retire_ready", 32'(issue_ready), 32'd1);
        step();
        idle(); issue_valid = 1'b1; issue_dest = 5'd3;
        check_all("sat_still_full");
        for (int i = 0; i < 3; i++) begin
            idle(); wb(5'd3, 32'h3000 + i);
            check_all("sat_drain");
            step();
        end

        // Simultaneous claim/retire on r4, then cross-register
        raddr1 = 5'd4; raddr2 = 5'd6;
        claim(5'd4);
        claim(5'd6);
        claim(5'd6);
        idle(); issue_valid = 1'b1; issue_dest = 5'd4; wb(5'd4, 32'h4444);
        check_all("r4_same");
        step();
        idle();
        check_all("r4_hold");
        issue_valid = 1'b1; issue_dest = 5'd4; wb(5'd6, 32'h6666);
        check_all("r4_r6_cross");
        step();
        idle();
        check_all("r4_r6_after");

        // Clear, with a register write in the same cycle
        claim(5'd12);
        claim(5'd10);
        claim(5'd10);
        raddr1 = 5'd10; raddr2 = 5'd12;
        idle(); sb_clear = 1'b1; wb(5'd12, 32'hFF);
        check_all("clear_cycle");
        step();
        idle();
        check_all("after_clear");
        chk("after_clear_busy", 32'(r1_busy), 32'd0);
        chk("after_clear_r12", rdata2, 32'hFF);

        // Asynchronous reset between edges
        raddr1 = 5'd12;
        #2 resetn = 1'b0;
        m_reset();
        check_all("async_rst");
        chk("async_rst_r12", rdata1, 32'h0);
        @(negedge clk);
        #3 resetn = 1'b1;
        @(negedge clk);
        check_all("post_async");

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            idle();
            issue_valid = 1'($urandom_range(0, 1));
            issue_dest  = 5'($urandom_range(0, 7));
            r = $urandom_range(1, 7);
            if (mcnt[r] > 0 && $urandom_range(0, 1) == 1) begin
                wb(5'(r), $urandom);
            end else if ($urandom_range(0, 7) == 0) begin
                wb(5'd0, $urandom);
            end
            sb_clear = ($urandom_range(0, 39) == 0);
            raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 7));
            raddr2 = ($urandom_range(0, 3) == 0) ? issue_dest : 5'($urandom_range(0, 31));
            check_all("rand");
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_regfile_sb
`default_nettype wire
